shift_arbiter: RTL and testbench

- Shares one combinational 16-bit shifter/rotator between two requesters: the execute stage (requester 0) and the address/immediate unit (requester 1).
- Each requester presents operand, count and opcode on a valid/ready handshake. The block arbitrates round-robin, registers the winner, drives the shared shifter and returns the registered result with a requester ID.
- Only one operation is outstanding at a time. Back-to-back throughput is one result per two cycles.

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_arbiter_if.sv | 47 ++++
 rtl/rr_arb2.sv | 30 +++
 rtl/shift_arbiter.sv | 101 ++++++++++
 tb/tb_shift_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter: opcode encodings, FSM states, width defaults.
package shift_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned CW_DEF = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Bundle of both requester handshakes, the response channel and the shared shifter hookup.
interface shift_arbiter_if #(
    parameter int unsigned DW = shift_pkg::DW_DEF,
    parameter int unsigned CW = shift_pkg::CW_DEF
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_in;
    logic [CW-1:0] req0_cnt;
    logic [1:0]    req0_op;

    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_in;
    logic [CW-1:0] req1_cnt;
    logic [1:0]    req1_op;

    logic          resp_valid;
    logic          resp_ready;
    logic          resp_id;
    logic [DW-1:0] resp_data;

    logic [DW-1:0] sh_in;
    logic [CW-1:0] sh_cnt;
    logic [1:0]    sh_op;
    logic [DW-1:0] sh_out;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_in, req0_cnt, req0_op,
        input  req1_valid, req1_in, req1_cnt, req1_op,
        input  resp_ready, sh_out,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data,
        output sh_in, sh_cnt, sh_op
    );

    // Requesters, consumer and shifter side.
    modport master (
        output req0_valid, req0_in, req0_cnt, req0_op,
        output req1_valid, req1_in, req1_cnt, req1_op,
        output resp_ready, sh_out,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data,
        input  sh_in, sh_cnt, sh_op
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves to the loser whenever an accept happens.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       en,
    output logic       grant
);

    logic prio_q;

    // A lone requester wins outright; ties and idle cycles fall to the pointer.
    always_comb begin
        grant = prio_q;
        unique case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = prio_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (en && (|valid)) begin
            prio_q <= ~grant;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one combinational shifter between two requesters, one op in flight at a time.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_arbiter_if.slave bus
);

    state_e        state_q;
    state_e        state_d;
    logic [1:0]    valid;
    logic          grant;
    logic          acc_en;
    logic          accept;

    logic [DW-1:0] op_in;
    logic [CW-1:0] op_cnt;
    logic [1:0]    op_op;
    logic          op_id;

    logic          resp_valid_q;
    logic          resp_id_q;
    logic [DW-1:0] resp_data_q;

    assign valid  = {bus.req1_valid, bus.req0_valid};
    // Retiring a result and accepting the next op may share a cycle.
    assign acc_en = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
    assign accept = acc_en && valid[grant];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .en    (acc_en),
        .grant (grant)
    );

    assign bus.req0_ready = acc_en && !grant;
    assign bus.req1_ready = acc_en && grant;

    assign bus.sh_in  = op_in;
    assign bus.sh_cnt = op_cnt;
    assign bus.sh_op  = op_op;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture from the winning requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_in  <= '0;
            op_cnt <= '0;
            op_op  <= 2'b00;
            op_id  <= 1'b0;
        end else if (accept) begin
            op_in  <= grant ? bus.req1_in  : bus.req0_in;
            op_cnt <= grant ? bus.req1_cnt : bus.req0_cnt;
            op_op  <= grant ? bus.req1_op  : bus.req0_op;
            op_id  <= grant;
        end
    end

    // Result register: loaded from the shifter in ISSUE, held under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
        end else if (state_q == ISSUE) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= op_id;
            resp_data_q  <= bus.sh_out;
        end else if ((state_q == RESP) && bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    shift_arbiter_if #(.DW(16), .CW(4)) bus ();

    shift_arbiter #(.DW(16), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] shf(logic [15:0] a, logic [3:0] c, logic [1:0] op);
        logic [31:0] d;
        d = {a, a} << c;
        case (op)
            OP_ROL:  return d[31:16];
            OP_SLL:  return a << c;
            OP_SRA:  return 16'($signed(a) >>> c);
            default: return a >> c;
        endcase
    endfunction

    // Behavioural shifter sitting on the shared port.
    always_comb bus.sh_out = shf(bus.sh_in, bus.sh_cnt, bus.sh_op);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one op in flight, result visible one cycle after accept, pointer to the loser.
    logic        m_pend, m_fresh, m_prio;
    logic [15:0] m_in;
    logic [3:0]  m_cnt;
    logic [1:0]  m_op;

    always @(negedge clk) begin
        logic       shown, acc, g;
        logic [1:0] v;
        if (!rst_n) begin
            m_pend = 0; m_fresh = 0; m_prio = 0;
            m_in = '0; m_cnt = '0; m_op = '0;
            sb.delete();
        end else begin
            shown = m_pend && !m_fresh;
            chk("resp_valid", 32'(bus.resp_valid), 32'(shown));
            acc = !m_pend || (shown && bus.resp_ready);
            v   = {bus.req1_valid, bus.req0_valid};
            g   = (v == 2'b10) ? 1'b1 : (v == 2'b01) ? 1'b0 : m_prio;
            chk("req0_ready", 32'(bus.req0_ready), 32'(acc && !g));
            chk("req1_ready", 32'(bus.req1_ready), 32'(acc && g));
            chk("sh_bus", {10'd0, bus.sh_op, bus.sh_cnt, bus.sh_in}, {10'd0, m_op, m_cnt, m_in});
            if (acc && v[g]) begin
                m_in  = g ? bus.req1_in  : bus.req0_in;
                m_cnt = g ? bus.req1_cnt : bus.req0_cnt;
                m_op  = g ? bus.req1_op  : bus.req0_op;
                sb.push_back('{id: g, data: shf(m_in, m_cnt, m_op)});
                m_prio  = !g;
                m_pend  = 1;
                m_fresh = 1;
            end else begin
                m_fresh = 0;
                if (shown && bus.resp_ready) m_pend = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake and checks stability under stall.
    logic        hold_prev;
    logic [16:0] held;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_prev = 0;
        end else if (bus.resp_valid) begin
            if (hold_prev) chk("resp_hold", 32'({bus.resp_id, bus.resp_data}), 32'(held));
            if (bus.resp_ready) begin
                hold_prev = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual=%h required=none", bus.resp_data);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                end
            end else begin
                hold_prev = 1;
                held      = {bus.resp_id, bus.resp_data};
            end
        end else begin
            hold_prev = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit r, logic v, logic [15:0] d, logic [3:0] c, logic [1:0] o);
        if (r) begin
            bus.req1_valid = v; bus.req1_in = d; bus.req1_cnt = c; bus.req1_op = o;
        end else begin
            bus.req0_valid = v; bus.req0_in = d; bus.req0_cnt = c; bus.req0_op = o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        logic w;
        set_req(0, 0, '0, '0, '0);
        set_req(1, 0, '0, '0, '0);
        bus.resp_ready = 1;

        // Reset values
        rst_n = 0;
        cyc(); cyc();
        chk("rst_req0_ready", 32'(bus.req0_ready), 1);
        chk("rst_req1_ready", 32'(bus.req1_ready), 0);
        chk("rst_sh", {10'd0, bus.sh_op, bus.sh_cnt, bus.sh_in}, 0);
        chk("rst_resp", {15'd0, bus.resp_valid, bus.resp_id, bus.resp_data}, 0);
        rst_n = 1;

        // Single request
        set_req(0, 1, 16'h8001, 4'd1, OP_ROL);
        #1 chk("t1_ready", 32'(bus.req0_ready), 1);
        cyc(); bus.req0_valid = 0;
        cyc();
        chk("t1_valid", 32'(bus.resp_valid), 1);
        chk("t1_id", 32'(bus.resp_id), 0);
        chk("t1_data", 32'(bus.resp_data), 32'h0003);
        cyc(); cyc();

        // Contention straight out of reset
        set_req(0, 1, 16'h00F0, 4'd4, OP_SLL);
        set_req(1, 1, 16'h8000, 4'd3, OP_SRA);
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
        #1 chk("t2_first_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'b01);
        cyc(); bus.req0_valid = 0;
        cyc();
        chk("t2_data0", {15'd0, bus.resp_id, bus.resp_data}, {15'd0, 1'b0, 16'h0F00});
        chk("t2_req1_ready", 32'(bus.req1_ready), 1);
        cyc(); bus.req1_valid = 0;
        cyc();
        chk("t2_data1", {15'd0, bus.resp_id, bus.resp_data}, {15'd0, 1'b1, 16'hF000});
        cyc(); cyc();

        // Sustained contention: six accepts alternating from requester 0
        n_acc = 0;
        for (int k = 0; k < 30 && n_acc < 6; k++) begin
            set_req(0, 1, 16'($urandom), 4'($urandom), 2'($urandom));
            set_req(1, 1, 16'($urandom), 4'($urandom), 2'($urandom));
            #1;
            if (bus.req0_ready || bus.req1_ready) begin
                w = bus.req1_ready;
                chk("t3_alternate", 32'(w), 32'(n_acc % 2));
                n_acc++;
            end
            cyc();
        end
        chk("t3_accepts", 32'(n_acc), 6);
        bus.req0_valid = 0; bus.req1_valid = 0;
        cyc(); cyc(); cyc();

        // Backpressure with both requesters waiting
        bus.resp_ready = 0;
        set_req(1, 1, 16'hFFFF, 4'd15, OP_SRL);
        cyc();
        set_req(0, 1, 16'h5555, 4'd2, OP_SLL);
        set_req(1, 1, 16'hAAAA, 4'd1, OP_SRL);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("t4_resp", {14'd0, bus.resp_valid, bus.resp_id, bus.resp_data}, {14'd0, 2'b11, 16'h0001});
            chk("t4_readys", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
            cyc();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.resp_ready = 1;
        cyc(); cyc(); cyc();

        // Back-to-back: retire and accept in the same cycle
        set_req(1, 1, 16'h00FF, 4'd4, OP_SLL);
        cyc(); bus.req1_valid = 0;
        cyc();
        set_req(0, 1, 16'h1234, 4'd8, OP_ROL);
        #1 chk("t5_ready", 32'(bus.req0_ready), 1);
        cyc(); bus.req0_valid = 0;
        chk("t5_gap", 32'(bus.resp_valid), 0);
        cyc();
        chk("t5_data", {14'd0, bus.resp_valid, bus.resp_id, bus.resp_data}, {14'd0, 2'b10, 16'h3412});
        cyc(); cyc();

        // Reset while an op is in ISSUE
        set_req(0, 1, 16'hBEEF, 4'd5, OP_SRA);
        cyc(); bus.req0_valid = 0;
        rst_n = 0;
        #1 chk("t6_async_drop", 32'(bus.resp_valid), 0);
        cyc(); cyc();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            chk("t6_no_stale", 32'(bus.resp_valid), 0);
            cyc();
        end

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            set_req(0, 1'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));
            set_req(1, 1'($urandom), 16'($urandom), 4'($urandom), 2'($urandom));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.resp_ready = 1;
        repeat (5) cyc();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
